// File: rtl/cpu_mem_arbiter.sv
// Two-master arbiter for a single SRAM-like port: instruction fetch (m0) and data access (m1).
// One outstanding transaction; define ARB_RR_EN for round-robin, otherwise fixed priority m1 > m0.
module cpu_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_req,
  input  logic                m0_wr,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_addr_ok,
  output logic                m0_data_ok,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_wr,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_addr_ok,
  output logic                m1_data_ok,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   winner;
  logic   owner_req;

`ifdef ARB_RR_EN
  logic last_grant_q;

  // On contention, hand the port to whoever did not get it last time.
  always_comb begin
    if (m0_req && m1_req) begin
      winner = ~last_grant_q;
    end else begin
      winner = m1_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_q <= 1'b0;
    end else if (state_q == StIdle && (m0_req || m1_req)) begin
      last_grant_q <= winner;
    end
  end
`else
  assign winner = m1_req;
`endif

  assign owner_req = owner_q ? m1_req : m0_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    bus_req    = 1'b0;
    bus_wr     = 1'b0;
    bus_wstrb  = '0;
    bus_addr   = '0;
    bus_wdata  = '0;
    m0_addr_ok = 1'b0;
    m1_addr_ok = 1'b0;
    m0_data_ok = 1'b0;
    m1_data_ok = 1'b0;
    case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          owner_d = winner;
          state_d = StAddr;
        end
      end
      StAddr: begin
        bus_req   = 1'b1;
        bus_wr    = owner_q ? m1_wr    : m0_wr;
        bus_wstrb = owner_q ? m1_wstrb : m0_wstrb;
        bus_addr  = owner_q ? m1_addr  : m0_addr;
        bus_wdata = owner_q ? m1_wdata : m0_wdata;
        if (bus_addr_ok) begin
          m0_addr_ok = ~owner_q;
          m1_addr_ok = owner_q;
          state_d    = StData;
        end else if (!owner_req) begin
          // Master withdrew before acceptance: abandon the request.
          state_d = StIdle;
        end
      end
      StData: begin
        if (bus_data_ok) begin
          m0_data_ok = ~owner_q;
          m1_data_ok = owner_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m0_rdata = m0_data_ok ? bus_rdata : '0;
  assign m1_rdata = m1_data_ok ? bus_rdata : '0;

endmodule
